// File: rtl/tm1638_pkg.sv
// Shared TM1638 command bytes, state encodings and frame helper for the bus scheduler.
package tm1638_pkg;

    localparam logic [7:0] CMD_WR_AUTO = 8'h40;
    localparam logic [7:0] CMD_RD_KEY  = 8'h42;
    localparam logic [7:0] CMD_ADDR0   = 8'hC0;
    localparam logic [7:0] CMD_DISP_ON = 8'h88;

    // Byte index of the last byte of each frame (DISP: 0x40, 0xC0, 16 data, 0x88|b)
    localparam int DISP_LAST_IDX = 18;
    localparam int KEY_LAST_IDX  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STB_LO,
        ST_SHIFT,
        ST_RD_REL,
        ST_STB_HI,
        ST_GAP
    } sched_state_t;

    typedef enum logic {
        GNT_DISP = 1'b0,
        GNT_KEY  = 1'b1
    } grant_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_LO,
        PH_HI
    } sh_phase_t;

    function automatic logic [7:0] disp_byte(input logic [4:0] idx,
                                             input logic [127:0] data,
                                             input logic [2:0] br);
        logic [7:0] b;
        b = 8'h00;
        if (idx == 5'd0)
            b = CMD_WR_AUTO;
        else if (idx == 5'd1)
            b = CMD_ADDR0;
        else if (idx == 5'(DISP_LAST_IDX))
            b = CMD_DISP_ON | {5'b0, br};
        else
            for (int k = 0; k < 16; k++)
                if (idx == 5'(k + 2))
                    b = data[k*8 +: 8];
        return b;
    endfunction

endpackage

// File: rtl/tm1638_byte_shifter.sv
// Shifts one byte LSB-first onto (dir=0) or off (dir=1) the TM1638 bus with
// HALF_PERIOD-cycle clock phases; the serial clock idles high between bytes.
module tm1638_byte_shifter
    import tm1638_pkg::*;
#(
    parameter int HALF_PERIOD = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dir,
    input  logic [7:0] din,
    input  logic       dio_i,
    output logic       sclk,
    output logic       dio_o,
    output logic [7:0] dout,
    output logic       done
);

    localparam int CW = $clog2(HALF_PERIOD) + 1;

    sh_phase_t     phase;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;
    logic          rd;
    logic          last;

    assign last = (cnt == CW'(HALF_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= PH_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            rd      <= 1'b0;
            sclk    <= 1'b1;
            dio_o   <= 1'b0;
            dout    <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        sh      <= din;
                        rd      <= dir;
                        bit_idx <= '0;
                        cnt     <= '0;
                        sclk    <= 1'b0;
                        dio_o   <= dir ? 1'b0 : din[0];
                        phase   <= PH_LO;
                    end
                end
                PH_LO: begin
                    if (last) begin
                        cnt   <= '0;
                        sclk  <= 1'b1;
                        phase <= PH_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_HI: begin
                    if (last) begin
                        cnt <= '0;
                        // Read bits enter at the top so the first bit lands in bit 0.
                        if (bit_idx == 3'd7) begin
                            dout  <= rd ? {dio_i, sh[7:1]} : sh;
                            done  <= 1'b1;
                            dio_o <= 1'b0;
                            phase <= PH_IDLE;
                        end else begin
                            sh      <= {rd ? dio_i : 1'b0, sh[7:1]};
                            dio_o   <= rd ? 1'b0 : sh[1];
                            bit_idx <= bit_idx + 1'b1;
                            sclk    <= 1'b0;
                            phase   <= PH_LO;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tm1638_bus_scheduler.sv
// TM1638 bus owner: arbitrates display refresh and key-scan frames onto CLK/STB/DIO.
// Define TM_KEY_DEBOUNCE_EN to accept a scan only when it matches the previous raw scan.
module tm1638_bus_scheduler
    import tm1638_pkg::*;
#(
    parameter int HALF_PERIOD    = 32,
    parameter int REFRESH_CYCLES = 500000,
    parameter int RD_WAIT        = 64
) (
    input  logic         clk_50M,
    input  logic         rst_n,
    input  logic [127:0] disp_data,
    input  logic         upd_req,
    input  logic         key_req,
    input  logic [2:0]   bright,
    output logic [31:0]  keys,
    output logic         keys_valid,
    output logic         busy,
    output logic         tm_clk,
    output logic         tm_stb,
    output logic         tm_dio_o,
    output logic         tm_dio_oe,
    input  logic         tm_dio_i
);

    localparam int TW   = $clog2(REFRESH_CYCLES);
    localparam int CMAX = (HALF_PERIOD > RD_WAIT) ? HALF_PERIOD : RD_WAIT;
    localparam int CW   = $clog2(CMAX) + 1;

    sched_state_t  state;
    grant_t        cur, last_grant;
    logic          disp_pend, key_pend;
    logic          gnt_disp, gnt_key;
    logic [TW-1:0] timer;
    logic          tick;
    logic [127:0]  data_q;
    logic [2:0]    bright_q;
    logic [4:0]    idx;
    logic [CW-1:0] cnt;
    logic          hp_last, rd_last, win_end;
    logic [7:0]    byte_cur, byte_nxt;
    logic          sh_start, sh_dir, sh_done;
    logic [7:0]    sh_din, sh_dout;
    logic [31:0]   scan;
    logic          scan_done;

    assign tick    = (timer == TW'(REFRESH_CYCLES - 1));
    assign hp_last = (cnt == CW'(HALF_PERIOD - 1));
    assign rd_last = (cnt == CW'(RD_WAIT - 1));

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)
            timer <= '0;
        else
            timer <= tick ? '0 : timer + 1'b1;
    end

    // Both pending: alternate away from the last granted type.
    always_comb begin
        gnt_disp = 1'b0;
        gnt_key  = 1'b0;
        if (state == ST_IDLE) begin
            if (disp_pend && (!key_pend || last_grant == GNT_KEY))
                gnt_disp = 1'b1;
            else if (key_pend)
                gnt_key = 1'b1;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            disp_pend <= 1'b0;
            key_pend  <= 1'b0;
        end else begin
            disp_pend <= (disp_pend & ~gnt_disp) | upd_req | tick;
            key_pend  <= (key_pend & ~gnt_key) | key_req | tick;
        end
    end

    always_comb begin
        byte_cur = 8'h00;
        byte_nxt = 8'h00;
        win_end  = 1'b0;
        if (cur == GNT_DISP) begin
            byte_cur = disp_byte(idx, data_q, bright_q);
            byte_nxt = disp_byte(idx + 5'd1, data_q, bright_q);
            win_end  = (idx == 5'd0) || (idx == 5'(DISP_LAST_IDX - 1)) ||
                       (idx == 5'(DISP_LAST_IDX));
        end else begin
            byte_cur = (idx == 5'd0) ? CMD_RD_KEY : 8'h00;
            win_end  = (idx == 5'(KEY_LAST_IDX));
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cur        <= GNT_DISP;
            last_grant <= GNT_KEY;
            busy       <= 1'b0;
            tm_stb     <= 1'b1;
            tm_dio_oe  <= 1'b1;
            data_q     <= '0;
            bright_q   <= '0;
            idx        <= '0;
            cnt        <= '0;
            sh_start   <= 1'b0;
            sh_dir     <= 1'b0;
            sh_din     <= '0;
            scan       <= '0;
            scan_done  <= 1'b0;
        end else begin
            sh_start  <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_disp || gnt_key) begin
                        busy     <= 1'b1;
                        cur      <= gnt_disp ? GNT_DISP : GNT_KEY;
                        data_q   <= disp_data;
                        bright_q <= bright;
                        idx      <= '0;
                        cnt      <= '0;
                        tm_stb   <= 1'b0;
                        state    <= ST_STB_LO;
                    end
                end
                ST_STB_LO: begin
                    if (hp_last) begin
                        cnt      <= '0;
                        sh_start <= 1'b1;
                        sh_din   <= byte_cur;
                        sh_dir   <= 1'b0;
                        state    <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (sh_done) begin
                        if (cur == GNT_KEY && idx != 5'd0)
                            scan <= {sh_dout, scan[31:8]};
                        if (cur == GNT_KEY && idx == 5'd0) begin
                            tm_dio_oe <= 1'b0;
                            cnt       <= '0;
                            idx       <= 5'd1;
                            state     <= ST_RD_REL;
                        end else if (win_end) begin
                            cnt   <= '0;
                            state <= ST_STB_HI;
                        end else begin
                            idx      <= idx + 5'd1;
                            sh_start <= 1'b1;
                            sh_din   <= byte_nxt;
                            sh_dir   <= (cur == GNT_KEY);
                        end
                    end
                end
                ST_RD_REL: begin
                    if (rd_last) begin
                        cnt      <= '0;
                        sh_start <= 1'b1;
                        sh_din   <= 8'h00;
                        sh_dir   <= 1'b1;
                        state    <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STB_HI: begin
                    if (hp_last) begin
                        cnt       <= '0;
                        tm_stb    <= 1'b1;
                        tm_dio_oe <= 1'b1;
                        scan_done <= (cur == GNT_KEY);
                        state     <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (hp_last) begin
                        cnt <= '0;
                        if (cur == GNT_DISP && idx != 5'(DISP_LAST_IDX)) begin
                            idx    <= idx + 5'd1;
                            tm_stb <= 1'b0;
                            state  <= ST_STB_LO;
                        end else begin
                            busy       <= 1'b0;
                            last_grant <= cur;
                            state      <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TM_KEY_DEBOUNCE_EN
    logic [31:0] raw_scan;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            keys       <= '0;
            keys_valid <= 1'b0;
            raw_scan   <= '0;
        end else begin
            keys_valid <= 1'b0;
            if (scan_done) begin
                raw_scan <= scan;
                if (scan == raw_scan) begin
                    keys       <= scan;
                    keys_valid <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            keys       <= '0;
            keys_valid <= 1'b0;
        end else begin
            keys_valid <= 1'b0;
            if (scan_done) begin
                keys       <= scan;
                keys_valid <= 1'b1;
            end
        end
    end
`endif

    tm1638_byte_shifter #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_shifter (
        .clk   (clk_50M),
        .rst_n (rst_n),
        .start (sh_start),
        .dir   (sh_dir),
        .din   (sh_din),
        .dio_i (tm_dio_i),
        .sclk  (tm_clk),
        .dio_o (tm_dio_o),
        .dout  (sh_dout),
        .done  (sh_done)
    );

endmodule

// File: tb/tb_tm1638_bus_scheduler.sv
// Directed bench for tm1638_bus_scheduler with a TM1638 bus model (frame decoder + key responder).
module tb_tm1638_bus_scheduler;

    logic         clk_50M = 1'b0;
    logic         rst_n;
    logic [127:0] disp_data;
    logic         upd_req, key_req;
    logic [2:0]   bright;
    logic [31:0]  keys;
    logic         keys_valid, busy, tm_clk, tm_stb, tm_dio_o, tm_dio_oe;
    logic         tm_dio_i = 1'b0;

    tm1638_bus_scheduler #(
        .HALF_PERIOD(2), .REFRESH_CYCLES(5000), .RD_WAIT(4)
    ) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .disp_data(disp_data), .upd_req(upd_req),
        .key_req(key_req), .bright(bright), .keys(keys), .keys_valid(keys_valid),
        .busy(busy), .tm_clk(tm_clk), .tm_stb(tm_stb), .tm_dio_o(tm_dio_o),
        .tm_dio_oe(tm_dio_oe), .tm_dio_i(tm_dio_i)
    );

    always #5 clk_50M = ~clk_50M;

    // Bus model state (only ever written by the model processes below)
    logic [7:0]  wr_bytes[$];
    int          wend[$];
    int          nwin = 0, nfall = 0, nrd = 0, bitc = 0, rbit = 0;
    logic [7:0]  cur_b = 8'h00;
    logic        stb_prev = 1'b1, clk_prev = 1'b1;
    logic [31:0] key_word = 32'h0;
    int          kv_cnt = 0, oe_viol = 0, busy_cyc = 0;

    always @(tm_clk or tm_stb) begin
        if (tm_stb !== stb_prev) begin
            if (tm_stb === 1'b0) begin
                nwin++; bitc = 0; rbit = 0;
            end else if (tm_stb === 1'b1) begin
                wend.push_back(wr_bytes.size());
            end
        end
        if (tm_clk !== clk_prev) begin
            if (tm_clk === 1'b1 && tm_stb === 1'b0) begin
                if (tm_dio_oe) begin
                    cur_b = {tm_dio_o, cur_b[7:1]};
                    bitc++;
                    if (bitc == 8) begin
                        wr_bytes.push_back(cur_b);
                        bitc = 0;
                    end
                end else begin
                    nrd++;
                end
            end else if (tm_clk === 1'b0) begin
                nfall++;
                if (!tm_dio_oe) begin
                    tm_dio_i = key_word[rbit[4:0]];
                    rbit++;
                end
            end
        end
        stb_prev = tm_stb;
        clk_prev = tm_clk;
    end

    always @(negedge clk_50M) begin
        if (keys_valid) kv_cnt++;
        if (!tm_dio_oe && tm_stb) oe_viol++;
        if (busy) busy_cyc++;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    task automatic pulse(input logic u, input logic k);
        upd_req = u; key_req = k;
        cyc(1);
        upd_req = 1'b0; key_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
    endtask

    // Wait until `need` bytes beyond `base` are written (and optionally the bus is idle).
    task automatic wait_bytes(input int base, input int need, input bit idle, input string tag);
        int  c;
        bit  ok;
        c = 0; ok = 1'b0;
        while (c < 20000 && !ok) begin
            cyc(1);
            c++;
            ok = ((wr_bytes.size() - base) >= need) && (!idle || !busy);
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    logic [7:0] exp1[19];
    int bb, bw, bf, bk, br, bo, bn, bc;

    initial begin
        rst_n = 1'b0; upd_req = 1'b0; key_req = 1'b0; bright = 3'd5;
        for (int k = 0; k < 16; k++) disp_data[k*8 +: 8] = 8'(k);
        cyc(2);
        chk("rst_pins", {26'b0, tm_clk, tm_stb, tm_dio_o, tm_dio_oe, keys_valid, busy}, 32'b110100);
        chk("rst_keys", keys, 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // 1: display frame
        bb = wr_bytes.size(); bw = wend.size(); bf = nfall; bn = nwin; bk = kv_cnt;
        pulse(1'b1, 1'b0);
        wait_bytes(bb, 19, 1'b1, "t1_done");
        exp1[0] = 8'h40; exp1[1] = 8'hC0; exp1[18] = 8'h8D;
        for (int k = 0; k < 16; k++) exp1[k+2] = 8'(k);
        for (int k = 0; k < 19; k++) chk($sformatf("t1_byte%0d", k), 32'(wr_bytes[bb+k]), 32'(exp1[k]));
        chk("t1_windows", nwin - bn, 3);
        chk("t1_wend0", wend[bw] - bb, 1);
        chk("t1_wend1", wend[bw+1] - bb, 18);
        chk("t1_wend2", wend[bw+2] - bb, 19);
        chk("t1_clocks", nfall - bf, 152);
        chk("t1_no_kv", kv_cnt - bk, 0);

        // 2: key scan
        key_word = 32'hA53C0F81;
        bb = wr_bytes.size(); bf = nfall; br = nrd; bo = oe_viol; bk = kv_cnt; bn = nwin;
        pulse(1'b0, 1'b1);
        wait_bytes(bb, 1, 1'b1, "t2_done");
        chk("t2_cmd", 32'(wr_bytes[bb]), 32'h42);
        chk("t2_keys", keys, 32'hA53C0F81);
        chk("t2_kv", kv_cnt - bk, 1);
        chk("t2_rdclk", nrd - br, 32);
        chk("t2_oe_window", oe_viol - bo, 0);
        chk("t2_clocks", nfall - bf, 40);
        chk("t2_windows", nwin - bn, 1);
        chk("t2_oe_idle", 32'(tm_dio_oe), 32'd1);

        // 3: simultaneous requests, alternation
        do_reset();
        key_word = 32'h0;
        bb = wr_bytes.size(); bn = nwin;
        pulse(1'b1, 1'b1);
        wait_bytes(bb, 20, 1'b0, "t3_key_start");
        pulse(1'b1, 1'b1);
        wait_bytes(bb, 40, 1'b1, "t3_done");
        chk("t3_first", 32'(wr_bytes[bb]), 32'h40);
        chk("t3_second", 32'(wr_bytes[bb+19]), 32'h42);
        chk("t3_third", 32'(wr_bytes[bb+20]), 32'h40);
        chk("t3_fourth", 32'(wr_bytes[bb+39]), 32'h42);
        chk("t3_windows", nwin - bn, 8);

        // 4: repeat requests merge
        do_reset();
        bb = wr_bytes.size(); bn = nwin;
        pulse(1'b1, 1'b0);
        cyc(20);  pulse(1'b1, 1'b0);
        cyc(100); pulse(1'b1, 1'b0);
        cyc(100); pulse(1'b1, 1'b0);
        wait_bytes(bb, 38, 1'b1, "t4_done");
        cyc(300);
        chk("t4_bytes", wr_bytes.size() - bb, 38);
        chk("t4_windows", nwin - bn, 6);
        chk("t4_idle", 32'(busy), 32'd0);

        // 5: reset in the middle of a read byte
        do_reset();
        key_word = 32'hFFFFFFFF;
        br = nrd; bk = kv_cnt;
        pulse(1'b0, 1'b1);
        begin
            int c; bit ok;
            c = 0; ok = 1'b0;
            while (c < 2000 && !ok) begin cyc(1); c++; ok = (nrd - br) >= 12; end
            chk("t5_reach_read", 32'(ok), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("t5_pins", {28'b0, tm_clk, tm_stb, tm_dio_o, tm_dio_oe}, 32'b1101);
        chk("t5_busy", 32'(busy), 32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        chk("t5_keys", keys, 32'h0);
        chk("t5_kv", kv_cnt - bk, 0);
        bc = busy_cyc; bb = wr_bytes.size();
        cyc(4000);
        chk("t5_quiet", busy_cyc - bc, 0);
        wait_bytes(bb, 20, 1'b1, "t5_timer_done");
        chk("t5_timer_disp", 32'(wr_bytes[bb]), 32'h40);
        chk("t5_timer_key", 32'(wr_bytes[bb+19]), 32'h42);

        // 6: three scans 0x10, 0x20, 0x20
        do_reset();
        bk = kv_cnt;
        key_word = 32'h10;
        bb = wr_bytes.size(); pulse(1'b0, 1'b1); wait_bytes(bb, 1, 1'b1, "t6_scan0");
        key_word = 32'h20;
        bb = wr_bytes.size(); pulse(1'b0, 1'b1); wait_bytes(bb, 1, 1'b1, "t6_scan1");
        bb = wr_bytes.size(); pulse(1'b0, 1'b1); wait_bytes(bb, 1, 1'b1, "t6_scan2");
        cyc(2);
`ifdef TM_KEY_DEBOUNCE_EN
        chk("t6_kv", kv_cnt - bk, 1);
`else
        chk("t6_kv", kv_cnt - bk, 3);
`endif
        chk("t6_keys", keys, 32'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
